gray_counter_hs: RTL

GRAY_COUNTER_HS -- requirements
Module: gray_counter_hs

---
 rtl/gray_pkg.sv | 18 +
 rtl/bin_to_gray.sv | 21 ++
 rtl/gray_counter_hs.sv | 121 ++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the handshaked Gray-code counter.
//   WIDTH_DEFAULT : default counter / code width
//   state_e       : handshake FSM states (IDLE = nothing offered, RUN = code offered)
//   bin2gray      : binary to reflected-binary Gray conversion (up to 16 bits)
package gray_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [15:0] bin2gray(input logic [15:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary to Gray converter.
//   WIDTH  : code width in bits (2..16)
//   bin_i  : binary input
//   gray_o : Gray code of bin_i
module bin_to_gray
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  logic [15:0] gray_full;

  always_comb begin
    gray_full = bin2gray(16'(bin_i));
    gray_o    = gray_full[WIDTH-1:0];
  end

endmodule

// File: rtl/gray_counter_hs.sv
// Up/down binary counter presenting its value as a registered Gray code over a
// valid/ready handshake. Each accepted code steps the count; a synchronous load
// overrides stepping. tc pulses alongside the code produced by a wrapping step.
//
// Optional feature: define GRAY_COUNTER_CHECK_EN to add the gray_err output, a
// sticky flag raised when two successive step-produced codes do not differ in
// exactly one bit (loads are not checked).
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   en        : run request / count enable
//   up_dn     : direction, 1 = increment, 0 = decrement (sampled on transfer only)
//   load      : synchronous load strobe
//   load_val  : binary value to load
//   gray_out  : registered Gray code of the internal count
//   out_valid : gray_out is offered for transfer
//   out_ready : consumer accepts gray_out this cycle
//   tc        : one-cycle terminal-count (wrap) pulse
//   gray_err  : (GRAY_COUNTER_CHECK_EN only) sticky Gray-step violation flag
module gray_counter_hs
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             tc
`ifdef GRAY_COUNTER_CHECK_EN
  ,
  output logic             gray_err
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;
  logic             xfer;
  logic             step;
  logic             wrap;

  always_comb begin
    xfer = (state_q == RUN) && out_ready;
    // A load wins over the step but the transfer itself still completes.
    step = xfer && !load;
    wrap = up_dn ? (bin_q == {WIDTH{1'b1}}) : (bin_q == {WIDTH{1'b0}});

    bin_d = bin_q;
    if (load) begin
      bin_d = load_val;
    end else if (xfer) begin
      bin_d = up_dn ? (bin_q + 1'b1) : (bin_q - 1'b1);
    end

    tc_d = step && wrap;

    state_d = state_q;
    unique case (state_q)
      IDLE: if (en) state_d = RUN;
      RUN:  if (xfer && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Converting the next-state count keeps gray_out aligned with bin_q.
  bin_to_gray #(
    .WIDTH(WIDTH)
  ) u_bin_to_gray (
    .bin_i (bin_d),
    .gray_o(gray_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      gray_q  <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      tc_q    <= tc_d;
    end
  end

  assign gray_out  = gray_q;
  assign out_valid = (state_q == RUN);
  assign tc        = tc_q;

`ifdef GRAY_COUNTER_CHECK_EN
  logic [WIDTH-1:0] gray_prev_q;
  logic             step_q;
  logic             err_q;

  // Compare the presented code against the one it replaced, one cycle after
  // each step, so the check sees what actually left the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_prev_q <= '0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      step_q <= step;
      if (step) gray_prev_q <= gray_q;
      if (step_q && ($countones(gray_q ^ gray_prev_q) != 1)) err_q <= 1'b1;
    end
  end

  assign gray_err = err_q;
`endif

endmodule
